// File: rtl/q_sys_descriptor_mem_arbiter.sv
// Round-robin two-requester arbiter and burst sequencer for the single-port descriptor RAM.
// Bursts become one RAM access per cycle; read data is steered back by a registered owner tag.
module q_sys_descriptor_mem_arbiter #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BURST_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     r0_address,
  input  logic                  r0_read,
  input  logic                  r0_write,
  input  logic [DATA_W-1:0]     r0_writedata,
  input  logic [DATA_W/8-1:0]   r0_byteenable,
  input  logic [BURST_W-1:0]    r0_burstcount,
  output logic                  r0_waitrequest,
  output logic [DATA_W-1:0]     r0_readdata,
  output logic                  r0_readdatavalid,
  input  logic [ADDR_W-1:0]     r1_address,
  input  logic                  r1_read,
  input  logic                  r1_write,
  input  logic [DATA_W-1:0]     r1_writedata,
  input  logic [DATA_W/8-1:0]   r1_byteenable,
  input  logic [BURST_W-1:0]    r1_burstcount,
  output logic                  r1_waitrequest,
  output logic [DATA_W-1:0]     r1_readdata,
  output logic                  r1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

  state_t               state;
  logic                 last_grant;
  logic                 owner;
  logic [ADDR_W-1:0]    next_addr;
  logic [BURST_W-1:0]   remaining;

  logic                 pend0, pend1, win, accept;
  logic                 owner_write, wbeat, issue, issue_write, issue_owner;
  logic                 win_write;
  logic [ADDR_W-1:0]    win_addr;
  logic [BURST_W-1:0]   win_burst;

  // Arbitration: on contention the requester that did not win last time is granted.
  always_comb begin
    pend0       = r0_read | r0_write;
    pend1       = r1_read | r1_write;
    win         = pend1 & (~pend0 | ~last_grant);
    accept      = (state == IDLE) & (pend0 | pend1);
    win_addr    = win ? r1_address : r0_address;
    win_burst   = win ? r1_burstcount : r0_burstcount;
    win_write   = win ? r1_write : r0_write;
    owner_write = owner ? r1_write : r0_write;
    wbeat       = (state == WBURST) & owner_write;
    issue       = accept | (state == RBURST) | wbeat;
    issue_write = accept ? win_write : wbeat;
    issue_owner = accept ? win : owner;
  end

  // RAM drive and stalls; reset forces every requester to wait and deselects the RAM.
  always_comb begin
    mem_address    = next_addr;
    mem_writedata  = owner ? r1_writedata : r0_writedata;
    mem_byteenable = owner ? r1_byteenable : r0_byteenable;
    if (accept) begin
      mem_address    = win_addr;
      mem_writedata  = win ? r1_writedata : r0_writedata;
      mem_byteenable = win ? r1_byteenable : r0_byteenable;
    end
    mem_chipselect = issue & ~reset;
    mem_write      = issue & issue_write & ~reset;
    mem_clken      = ~reset;
    r0_waitrequest = reset | ~((accept & ~win) | (wbeat & ~owner));
    r1_waitrequest = reset | ~((accept & win) | (wbeat & owner));
  end

  assign r0_readdata = mem_readdata;
  assign r1_readdata = mem_readdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      owner            <= 1'b0;
      next_addr        <= '0;
      remaining        <= '0;
      r0_readdatavalid <= 1'b0;
      r1_readdatavalid <= 1'b0;
    end else begin
      r0_readdatavalid <= issue & ~issue_write & ~issue_owner;
      r1_readdatavalid <= issue & ~issue_write & issue_owner;
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= win;
            // Bursts of 0 or 1 complete in the accept cycle, keeping IDLE free for back-to-back singles.
            if (win_burst > BURST_W'(1)) begin
              owner     <= win;
              next_addr <= win_addr + ADDR_W'(1);
              remaining <= win_burst - BURST_W'(1);
              state     <= win_write ? WBURST : RBURST;
            end
          end
        end
        RBURST: begin
          next_addr <= next_addr + ADDR_W'(1);
          remaining <= remaining - BURST_W'(1);
          if (remaining == BURST_W'(1)) state <= IDLE;
        end
        WBURST: begin
          if (wbeat) begin
            next_addr <= next_addr + ADDR_W'(1);
            remaining <= remaining - BURST_W'(1);
            if (remaining == BURST_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_sys_descriptor_mem_arbiter.sv
// Self-checking bench for q_sys_descriptor_mem_arbiter: a RAM model behind the DUT,
// a shadow memory as reference, directed scenarios plus randomized sequential traffic.
module tb_q_sys_descriptor_mem_arbiter;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned EW = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] r0_address, r1_address;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic [DW-1:0] r0_writedata, r1_writedata;
  logic [EW-1:0] r0_byteenable, r1_byteenable;
  logic [BW-1:0] r0_burstcount, r1_burstcount;
  logic          r0_waitrequest, r1_waitrequest;
  logic [DW-1:0] r0_readdata, r1_readdata;
  logic          r0_readdatavalid, r1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic [EW-1:0] mem_byteenable;

  logic [DW-1:0] ram    [0:DEPTH-1];
  logic [DW-1:0] shadow [0:DEPTH-1];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  q_sys_descriptor_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk(clk), .reset(reset),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable), .r0_burstcount(r0_burstcount),
    .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable), .r1_burstcount(r1_burstcount),
    .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // Single-port RAM: registered read data one cycle after the address, byte-lane writes.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < int'(EW); b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [EW-1:0] be, input logic [BW-1:0] bc);
    if (r == 0) begin
      r0_read = rd; r0_write = wr; r0_address = a; r0_writedata = d; r0_byteenable = be; r0_burstcount = bc;
    end else begin
      r1_read = rd; r1_write = wr; r1_address = a; r1_writedata = d; r1_byteenable = be; r1_burstcount = bc;
    end
  endtask

  task automatic clear_req(input int r);
    set_req(r, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  function automatic logic get_wait(input int r);
    return (r == 0) ? r0_waitrequest : r1_waitrequest;
  endfunction

  function automatic logic get_rdv(input int r);
    return (r == 0) ? r0_readdatavalid : r1_readdatavalid;
  endfunction

  function automatic logic [DW-1:0] get_rdata(input int r);
    return (r == 0) ? r0_readdata : r1_readdata;
  endfunction

  // Reference write: only enabled byte lanes change.
  task automatic sh_write(input int addr, input logic [DW-1:0] d, input logic [EW-1:0] be);
    for (int b = 0; b < int'(EW); b++)
      if (be[b]) shadow[addr % DEPTH][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic test_reset;
    set_req(0, 1'b1, 1'b0, AW'(16), '0, '1, BW'(1));
    set_req(1, 1'b1, 1'b0, AW'(32), '0, '1, BW'(1));
    repeat (2) tick;
    #1;
    vectors++;
    if (r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_wait r0=%b r1=%b required 1,1", r0_waitrequest, r1_waitrequest);
    end
    vectors++;
    if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mem cs=%b wr=%b clken=%b required 0,0,0", mem_chipselect, mem_write, mem_clken);
    end
    vectors++;
    if (r0_readdatavalid !== 1'b0 || r1_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rdv r0=%b r1=%b required 0,0", r0_readdatavalid, r1_readdatavalid);
    end
    clear_req(0);
    clear_req(1);
    reset = 1'b0;
    tick;
    vectors++;
    if (mem_clken !== 1'b1) begin
      miscompares++;
      $display("FAIL clken_after_reset got %b required 1", mem_clken);
    end
  endtask

  // Load every RAM word with random data through single writes from alternating requesters.
  task automatic test_fill;
    logic [DW-1:0] d;
    int r;
    for (int a = 0; a < DEPTH; a++) begin
      r = a % 2;
      d = $urandom;
      set_req(r, 1'b0, 1'b1, AW'(a), d, '1, BW'(1));
      #1;
      vectors++;
      if (get_wait(r) !== 1'b0 || mem_address !== AW'(a) || mem_write !== 1'b1) begin
        miscompares++;
        $display("FAIL fill addr %0d wait=%b mem_addr=%0h mem_wr=%b required 0,%0h,1",
                 a, get_wait(r), mem_address, mem_write, a);
      end
      sh_write(a, d, '1);
      tick;
      clear_req(r);
    end
  endtask

  task automatic test_single_read;
    set_req(0, 1'b0, 1'b1, AW'(16), 32'hDEADBEEF, '1, BW'(1));
    #1;
    sh_write(16, 32'hDEADBEEF, '1);
    tick;
    set_req(0, 1'b1, 1'b0, AW'(16), '0, '1, BW'(1));
    #1;
    vectors++;
    if (r0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_address !== AW'(16)) begin
      miscompares++;
      $display("FAIL single_issue wait=%b cs=%b wr=%b addr=%0h required 0,1,0,010",
               r0_waitrequest, mem_chipselect, mem_write, mem_address);
    end
    tick;
    clear_req(0);
    #1;
    vectors++;
    if (r0_readdatavalid !== 1'b1 || r0_readdata !== 32'hDEADBEEF || r1_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_return rdv0=%b data=%h rdv1=%b required 1,deadbeef,0",
               r0_readdatavalid, r0_readdata, r1_readdatavalid);
    end
    tick;
    vectors++;
    if (r0_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_one_beat rdv0=%b required 0", r0_readdatavalid);
    end
  endtask

  // Both requesters reading every cycle: strict alternation from r0 after reset.
  task automatic test_alternating;
    int k0, k1, pw, paddr, ew;
    k0 = 0; k1 = 0; pw = -1; paddr = 0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      set_req(0, 1'b1, 1'b0, AW'(32 + k0), '0, '1, BW'(1));
      set_req(1, 1'b1, 1'b0, AW'(64 + k1), '0, '1, BW'(1));
      #1;
      ew = c % 2;
      vectors++;
      if (get_wait(ew) !== 1'b0 || get_wait(1 - ew) !== 1'b1) begin
        miscompares++;
        $display("FAIL alt_grant cyc %0d r0_wait=%b r1_wait=%b required winner r%0d",
                 c, r0_waitrequest, r1_waitrequest, ew);
      end
      if (pw >= 0) begin
        vectors++;
        if (get_rdv(pw) !== 1'b1 || get_rdv(1 - pw) !== 1'b0 || get_rdata(pw) !== shadow[paddr]) begin
          miscompares++;
          $display("FAIL alt_return cyc %0d r%0d rdv=%b other=%b data=%h required 1,0,%h",
                   c, pw, get_rdv(pw), get_rdv(1 - pw), get_rdata(pw), shadow[paddr]);
        end
      end
      pw = ew;
      paddr = (ew == 0) ? 32 + k0 : 64 + k1;
      if (ew == 0) k0++; else k1++;
      tick;
    end
    clear_req(0);
    clear_req(1);
    #1;
    vectors++;
    if (get_rdv(pw) !== 1'b1 || get_rdata(pw) !== shadow[paddr]) begin
      miscompares++;
      $display("FAIL alt_last_return rdv=%b data=%h required 1,%h", get_rdv(pw), get_rdata(pw), shadow[paddr]);
    end
    tick;
  endtask

  task automatic test_read_burst_wrap;
    int ea;
    // r0 goes last so that r1 wins the upcoming contention.
    set_req(0, 1'b1, 1'b0, AW'(16), '0, '1, BW'(1));
    tick;
    clear_req(0);
    tick;
    for (int c = 0; c < 5; c++) begin
      set_req(0, 1'b1, 1'b0, AW'(16), '0, '1, BW'(1));
      if (c == 0) set_req(1, 1'b1, 1'b0, AW'(2046), '0, '1, BW'(4));
      else clear_req(1);
      #1;
      vectors++;
      if (c < 4) begin
        ea = (2046 + c) % DEPTH;
        if (r0_waitrequest !== 1'b1 || r1_waitrequest !== (c == 0 ? 1'b0 : 1'b1) ||
            mem_chipselect !== 1'b1 || mem_address !== AW'(ea)) begin
          miscompares++;
          $display("FAIL rburst_issue cyc %0d w0=%b w1=%b cs=%b addr=%0h required 1,%0d,1,%0h",
                   c, r0_waitrequest, r1_waitrequest, mem_chipselect, mem_address, (c == 0) ? 0 : 1, ea);
        end
      end else if (r0_waitrequest !== 1'b0) begin
        miscompares++;
        $display("FAIL rburst_r0_grant w0=%b required 0", r0_waitrequest);
      end
      if (c > 0) begin
        ea = (2046 + c - 1) % DEPTH;
        vectors++;
        if (r1_readdatavalid !== 1'b1 || r0_readdatavalid !== 1'b0 || r1_readdata !== shadow[ea]) begin
          miscompares++;
          $display("FAIL rburst_beat %0d rdv1=%b rdv0=%b data=%h required 1,0,%h",
                   c - 1, r1_readdatavalid, r0_readdatavalid, r1_readdata, shadow[ea]);
        end
      end
      tick;
    end
    clear_req(0);
    #1;
    vectors++;
    if (r0_readdatavalid !== 1'b1 || r1_readdatavalid !== 1'b0 || r0_readdata !== shadow[16]) begin
      miscompares++;
      $display("FAIL rburst_after rdv0=%b rdv1=%b data=%h required 1,0,%h",
               r0_readdatavalid, r1_readdatavalid, r0_readdata, shadow[16]);
    end
    tick;
  endtask

  task automatic test_write_burst_gap;
    logic [DW-1:0] d [3];
    logic [DW-1:0] nd, want;
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    set_req(0, 1'b0, 1'b1, AW'(256), d[0], '1, BW'(3));
    #1;
    vectors++;
    if (r0_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_address !== AW'(256) || mem_writedata !== d[0]) begin
      miscompares++;
      $display("FAIL wburst_beat0 w0=%b wr=%b addr=%0h data=%h required 0,1,100,%h",
               r0_waitrequest, mem_write, mem_address, mem_writedata, d[0]);
    end
    sh_write(256, d[0], '1);
    tick;
    clear_req(0);
    set_req(1, 1'b1, 1'b0, AW'(48), '0, '1, BW'(1));
    #1;
    vectors++;
    if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || r1_waitrequest !== 1'b1 || r0_waitrequest !== 1'b1) begin
      miscompares++;
      $display("FAIL wburst_idle cs=%b wr=%b w1=%b w0=%b required 0,0,1,1",
               mem_chipselect, mem_write, r1_waitrequest, r0_waitrequest);
    end
    tick;
    for (int i = 1; i < 3; i++) begin
      set_req(0, 1'b0, 1'b1, AW'(1023), d[i], '1, BW'(3));
      #1;
      vectors++;
      if (r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1 || mem_write !== 1'b1 ||
          mem_address !== AW'(256 + i) || mem_writedata !== d[i]) begin
        miscompares++;
        $display("FAIL wburst_beat%0d w0=%b w1=%b wr=%b addr=%0h data=%h required 0,1,1,%0h,%h",
                 i, r0_waitrequest, r1_waitrequest, mem_write, mem_address, mem_writedata, 256 + i, d[i]);
      end
      sh_write(256 + i, d[i], '1);
      tick;
    end
    clear_req(0);
    #1;
    vectors++;
    if (r1_waitrequest !== 1'b0) begin
      miscompares++;
      $display("FAIL wburst_r1_grant w1=%b required 0", r1_waitrequest);
    end
    tick;
    clear_req(1);
    #1;
    vectors++;
    if (r1_readdatavalid !== 1'b1 || r1_readdata !== shadow[48]) begin
      miscompares++;
      $display("FAIL wburst_r1_data rdv=%b data=%h required 1,%h", r1_readdatavalid, r1_readdata, shadow[48]);
    end
    // Read the burst back.
    set_req(0, 1'b1, 1'b0, AW'(256), '0, '1, BW'(3));
    tick;
    clear_req(0);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (r0_readdatavalid !== 1'b1 || r0_readdata !== d[i]) begin
        miscompares++;
        $display("FAIL wburst_readback %0d rdv=%b data=%h required 1,%h", i, r0_readdatavalid, r0_readdata, d[i]);
      end
      tick;
    end
    // Lane-masked write: only the low two bytes change.
    nd = $urandom;
    want = {d[1][31:16], nd[15:0]};
    set_req(0, 1'b0, 1'b1, AW'(257), nd, EW'(4'b0011), BW'(1));
    sh_write(257, nd, EW'(4'b0011));
    tick;
    set_req(0, 1'b1, 1'b0, AW'(257), '0, '1, BW'(1));
    tick;
    clear_req(0);
    #1;
    vectors++;
    if (r0_readdatavalid !== 1'b1 || r0_readdata !== want) begin
      miscompares++;
      $display("FAIL lane_mask rdv=%b data=%h required 1,%h", r0_readdatavalid, r0_readdata, want);
    end
    tick;
  endtask

  task automatic test_reset_mid_burst;
    set_req(0, 1'b1, 1'b0, AW'(512), '0, '1, BW'(8));
    tick;
    clear_req(0);
    tick;
    set_req(0, 1'b1, 1'b0, AW'(600), '0, '1, BW'(1));
    set_req(1, 1'b1, 1'b0, AW'(700), '0, '1, BW'(1));
    reset = 1'b1;
    #1;
    vectors++;
    if (r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1 || mem_chipselect !== 1'b0 || r0_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_hold w0=%b w1=%b cs=%b rdv0=%b required 1,1,0,0",
               r0_waitrequest, r1_waitrequest, mem_chipselect, r0_readdatavalid);
    end
    tick;
    reset = 1'b0;
    #1;
    vectors++;
    if (r0_readdatavalid !== 1'b0 || r1_readdatavalid !== 1'b0 || r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_after rdv0=%b rdv1=%b w0=%b w1=%b required 0,0,0,1",
               r0_readdatavalid, r1_readdatavalid, r0_waitrequest, r1_waitrequest);
    end
    tick;
    clear_req(0);
    clear_req(1);
    #1;
    vectors++;
    if (r0_readdatavalid !== 1'b1 || r1_readdatavalid !== 1'b0 || r0_readdata !== shadow[600]) begin
      miscompares++;
      $display("FAIL midreset_first rdv0=%b rdv1=%b data=%h required 1,0,%h",
               r0_readdatavalid, r1_readdatavalid, r0_readdata, shadow[600]);
    end
    tick;
    vectors++;
    if (r0_readdatavalid !== 1'b0 || r1_readdatavalid !== 1'b0 || mem_chipselect !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_abandon rdv0=%b rdv1=%b cs=%b required 0,0,0",
               r0_readdatavalid, r1_readdatavalid, mem_chipselect);
    end
  endtask

  task automatic test_burst0;
    int a1, a2;
    a1 = int'($urandom_range(0, DEPTH - 1));
    a2 = int'($urandom_range(0, DEPTH - 1));
    set_req(1, 1'b1, 1'b0, AW'(a1), '0, '1, BW'(0));
    #1;
    vectors++;
    if (r1_waitrequest !== 1'b0) begin
      miscompares++;
      $display("FAIL burst0_accept w1=%b required 0", r1_waitrequest);
    end
    tick;
    set_req(1, 1'b1, 1'b0, AW'(a2), '0, '1, BW'(1));
    #1;
    vectors++;
    if (r1_readdatavalid !== 1'b1 || r1_readdata !== shadow[a1] || r1_waitrequest !== 1'b0) begin
      miscompares++;
      $display("FAIL burst0_beat rdv1=%b data=%h w1=%b required 1,%h,0",
               r1_readdatavalid, r1_readdata, r1_waitrequest, shadow[a1]);
    end
    tick;
    clear_req(1);
    #1;
    vectors++;
    if (r1_readdatavalid !== 1'b1 || r1_readdata !== shadow[a2]) begin
      miscompares++;
      $display("FAIL burst0_next rdv1=%b data=%h required 1,%h", r1_readdatavalid, r1_readdata, shadow[a2]);
    end
    tick;
    vectors++;
    if (r1_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL burst0_single rdv1=%b required 0", r1_readdatavalid);
    end
  endtask

  // Random reads/writes from one requester at a time, checked against the shadow memory.
  task automatic test_random;
    int r, n, a, got, w, gap, ea;
    logic wr;
    logic [BW-1:0] bc;
    logic [DW-1:0] d;
    logic [EW-1:0] be;
    for (int t = 0; t < 40; t++) begin
      r  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = int'($urandom_range(0, DEPTH - 1));
      bc = BW'($urandom);
      n  = (bc == '0) ? 1 : int'(bc);
      if (!wr) begin
        set_req(r, 1'b1, 1'b0, AW'(a), '0, '1, bc);
        w = 0;
        #1;
        while (get_wait(r) !== 1'b0 && w < 20) begin tick; #1; w++; end
        vectors++;
        if (w >= 20) begin
          miscompares++;
          $display("FAIL rand_read_accept txn %0d waited %0d cycles, required under 20", t, w);
        end
        tick;
        clear_req(r);
        got = 0;
        for (int c = 0; c < n + 3; c++) begin
          #1;
          if (get_rdv(1 - r) !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL rand_wrong_owner txn %0d rdv r%0d=%b required 0", t, 1 - r, get_rdv(1 - r));
          end
          if (get_rdv(r) === 1'b1) begin
            ea = (a + got) % DEPTH;
            vectors++;
            if (get_rdata(r) !== shadow[ea]) begin
              miscompares++;
              $display("FAIL rand_read txn %0d beat %0d addr %0h data=%h required %h",
                       t, got, ea, get_rdata(r), shadow[ea]);
            end
            got++;
          end
          tick;
        end
        vectors++;
        if (got != n) begin
          miscompares++;
          $display("FAIL rand_beats txn %0d got %0d beats required %0d", t, got, n);
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          gap = (i == 0) ? 0 : int'($urandom_range(0, 2));
          repeat (gap) tick;
          d  = $urandom;
          be = EW'($urandom);
          set_req(r, 1'b0, 1'b1, AW'(a), d, be, bc);
          w = 0;
          #1;
          while (get_wait(r) !== 1'b0 && w < 20) begin tick; #1; w++; end
          ea = (a + i) % DEPTH;
          vectors++;
          if (w >= 20 || mem_write !== 1'b1 || mem_address !== AW'(ea)) begin
            miscompares++;
            $display("FAIL rand_write txn %0d beat %0d waited %0d wr=%b addr=%0h required <20,1,%0h",
                     t, i, w, mem_write, mem_address, ea);
          end
          sh_write(ea, d, be);
          tick;
          clear_req(r);
        end
      end
    end
    // Read back a random selection to confirm write data and lane masking.
    for (int k = 0; k < 16; k++) begin
      a = int'($urandom_range(0, DEPTH - 1));
      set_req(0, 1'b1, 1'b0, AW'(a), '0, '1, BW'(1));
      tick;
      clear_req(0);
      #1;
      vectors++;
      if (r0_readdatavalid !== 1'b1 || r0_readdata !== shadow[a]) begin
        miscompares++;
        $display("FAIL rand_readback addr %0h rdv=%b data=%h required 1,%h", a, r0_readdatavalid, r0_readdata, shadow[a]);
      end
      tick;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout, simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_req(0);
    clear_req(1);
    test_reset;
    test_fill;
    test_single_read;
    test_alternating;
    test_read_burst_wrap;
    test_write_burst_gap;
    test_reset_mid_burst;
    test_burst0;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/q_sys_descriptor_mem_arbiter.md
Name: q_sys_descriptor_mem_arbiter

Overview:
- Two-requester Avalon-MM arbiter and burst sequencer in front of the 2048x32 single-port descriptor RAM. The RAM has 1-cycle read latency and an unregistered output.
- Requester 0 is the SGDMA read-side descriptor fetcher; requester 1 is the write-side descriptor fetcher/updater.
- Grants are round-robin. The block expands incrementing bursts into per-word RAM accesses and routes read data back to the owning requester.

Parameters:
- ADDR_W, 11, word address width; RAM depth is 2**ADDR_W.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- BURST_W, 4, burstcount width; legal bursts are 1..2**BURST_W-1, and 0 is treated as 1.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- rN_address  in  ADDR_W  word address (N = 0,1 for every rN_ port).
- rN_read  in  1  read request.
- rN_write  in  1  write request / write beat.
- rN_writedata  in  DATA_W  write data.
- rN_byteenable  in  DATA_W/8  byte lanes.
- rN_burstcount  in  BURST_W  beats; sampled only at command accept.
- rN_waitrequest  out  1  stall.
- rN_readdata  out  DATA_W  read data.
- rN_readdatavalid  out  1  read beat valid.
- mem_address  out  ADDR_W  RAM address.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_byteenable  out  DATA_W/8  RAM byte lanes.
- mem_clken  out  1  RAM clock enable; equals ~reset.
- mem_readdata  in  DATA_W  RAM read data, valid the cycle after the address.

Behaviour:
- Reset (async):
  - state=IDLE, last_grant=1 (r0 wins the first contention), counters and owner cleared.
  - rN_readdatavalid=0.
  - While reset is high, rN_waitrequest=1 and mem_chipselect/mem_write=0 (combinational override).
- State IDLE:
  - A requester is pending when read|write is high.
  - Exactly one pending requester wins; if both are pending, the one != last_grant wins.
  - The winner's waitrequest is low the same cycle, combinationally; the loser's is high.
  - Memory is driven from the winner's address/data/byteenable with chipselect=1 and write=winner write. The first beat issues in the accept cycle.
  - last_grant<=winner.
  - If burstcount<=1: stay IDLE, so single-word accesses can be accepted every cycle.
  - Else go to RBURST or WBURST: owner<=winner, next_addr<=address+1, remaining<=burstcount-1.
- State RBURST:
  - Each cycle: issue read at next_addr, next_addr++, remaining--.
  - Both requesters' waitrequest stay high.
  - After the cycle that issues remaining==1, return to IDLE.
- State WBURST:
  - The owner's waitrequest is low only while the owner's write is high; each such cycle writes one beat at next_addr with the owner's data/byteenable.
  - Owner idle cycles (write low) issue nothing and do not count.
  - The non-owner is stalled.
  - Return to IDLE after the last beat.
- Address arithmetic: next_addr increments modulo 2**ADDR_W; 2047+1 wraps to 0.
- Read return:
  - For every issued read, a registered valid plus owner tag raise rN_readdatavalid for exactly one cycle, 1 cycle after issue.
  - rN_readdata = mem_readdata, passed combinationally to both requesters; qualify with valid only.
  - Read latency is fixed at 1; no reordering.
- Simultaneous events: the final burst beat and a new request in the same cycle → the new request is accepted no earlier than the next cycle.
- Protocol violations are undefined and not verified: read and write asserted together, or an owner asserting read during WBURST.
- Reset mid-burst: burst abandoned immediately, no further readdatavalid, state IDLE.

Test Plan:
- r0 single read addr 0x010 (RAM preloaded 0x010=0xDEADBEEF) → r0_waitrequest low in cycle 0, r0_readdatavalid in cycle 1 with 0xDEADBEEF; r1_readdatavalid stays 0.
- r0 and r1 single reads asserted every cycle, continuously → accepts alternate r0,r1,r0,… starting with r0; one accept per cycle; each requester sees readdatavalid exactly 1 cycle after its own accept.
- r1 read burst addr 0x7FE, burstcount 4 → mem_address 0x7FE,0x7FF,0x000,0x001 on consecutive cycles; 4 r1_readdatavalid beats; r0 (requesting throughout) stalled 4 cycles, then granted.
- r0 write burst addr 0x100, burstcount 3, with one idle cycle between beats 1 and 2 → words 0x100..0x102 written; no mem_write in the idle cycle; r1 stalled until beat 3 completes. Read back each word with byteenable=4'b0011 writes checked for lane masking.
- Reset asserted during cycle 2 of an 8-beat read burst → no readdatavalid on the cycle after reset; waitrequest high during reset; first request after reset goes to r0 when both are pending.
- burstcount=0 read → treated as single beat; exactly one readdatavalid, state stays IDLE.
